// File: rtl/fifo_stream_reader.sv
// Read-side controller for a show-ahead fifo: drains it into a registered valid/ready
// stream through a two-entry skid buffer and tags every BURST_LEN-th beat as last.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [15:0]           beat_cnt
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(BURST_LEN - 1);

    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_e0;
    logic [DATA_WIDTH-1:0] r_e1;
    logic [BW-1:0]         r_bcnt;
    logic [15:0]           r_beat_cnt;

    logic w_push;
    logic w_xfer;

    // Pop decision uses only registered occupancy, so out_ready never reaches fifo_rd_en.
    assign w_push = !rst && !fifo_empty && (r_occ < 2'd2);
    assign w_xfer = (r_occ != 2'd0) && out_ready;

    assign fifo_rd_en = w_push;
    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_e0;
    assign out_last   = out_valid && (r_bcnt == BCNT_LAST);
    assign beat_cnt   = r_beat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_e0       <= '0;
            r_e1       <= '0;
            r_bcnt     <= '0;
            r_beat_cnt <= 16'd0;
        end else begin
            if (w_xfer) begin
                r_bcnt     <= (r_bcnt == BCNT_LAST) ? '0 : r_bcnt + 1'b1;
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            case ({w_push, w_xfer})
                2'b10: begin
                    if (r_occ == 2'd0) r_e0 <= fifo_dout;
                    else               r_e1 <= fifo_dout;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_occ <= r_occ - 2'd1;
                end
                // push with transfer implies occ==1: new beat replaces the departing head
                2'b11: r_e0 <= fifo_dout;
                default: ;
            endcase
        end
    end

endmodule
